// File: rtl/series_dispatcher_pkg.sv
// Shared definitions for the series-evaluation dispatcher and engine.
//   SERIES_W     : operand/result width used by dispatcher and engine
//   disp_state_t : dispatcher job FSM states
package series_pkg;

  localparam int unsigned SERIES_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_GUARD,
    S_WAIT,
    S_CAPTURE
  } disp_state_t;

endpackage

// File: rtl/series_dispatcher_if.sv
// Valid/ready stream carrying one W-bit word per handshake.
//   valid : producer has a word on data
//   ready : consumer takes the word when valid && ready
//   data  : W-bit payload
// master = producer side, slave = consumer side.
interface series_stream_if
  import series_pkg::*;
#(
  parameter int unsigned W = SERIES_W
);

  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport master (output valid, output data, input  ready);
  modport slave  (input  valid, input  data, output ready);

endinterface

// File: rtl/series_dispatcher_fifo.sv
// Synchronous result FIFO.
//   clk, rst_n : clock, asynchronous active-low reset (empties FIFO, clears storage)
//   wr_en      : write wr_data (ignored when full)
//   full       : no free entries
//   free_cnt   : number of free entries (0..DEPTH)
//   rd_en      : pop the head (ignored when empty)
//   rd_data    : current head entry
//   empty      : no stored entries
module result_fifo #(
  parameter int unsigned W     = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [W-1:0]             wr_data,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   free_cnt,
  input  logic                     rd_en,
  output logic [W-1:0]             rd_data,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]  wptr_q, rptr_q;
  logic [AW:0]  count;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_wr, do_rd;

  // Pointers carry one extra bit so full and empty are distinguishable.
  always_comb begin
    count    = wptr_q - rptr_q;
    full     = (count == (AW+1)'(DEPTH));
    empty    = (count == '0);
    free_cnt = (AW+1)'(DEPTH) - count;
    do_wr    = wr_en && !full;
    do_rd    = rd_en && !empty;
    rd_data  = mem_q[rptr_q[AW-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_wr) begin
        mem_q[wptr_q[AW-1:0]] <= wr_data;
        wptr_q                <= wptr_q + (AW+1)'(1);
      end
      if (do_rd) rptr_q <= rptr_q + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/series_dispatcher.sv
// Dispatcher wrapping the series-evaluation engine.
//   clk, rst_n  : clock, asynchronous active-low reset
//   in_s        : operand stream (slave); one engine job per accepted word
//   out_m       : result stream (master) fed from the result FIFO head
//   eng_x       : operand held to the engine for the whole job
//   eng_start   : one-cycle start pulse per job
//   eng_done    : raw engine done flag (may be high outside a job)
//   eng_result  : engine answer, captured when a qualified done is seen
//   busy        : job FSM not idle
//   timeout_err : sticky, set when a job is aborted for lack of done
//   jobs_done   : results written to the FIFO, wraps at 8 bits
module series_dispatcher
  import series_pkg::*;
#(
  parameter int unsigned W       = SERIES_W,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned MIN_LAT = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  series_stream_if.slave      in_s,
  series_stream_if.master     out_m,
  output logic [W-1:0]        eng_x,
  output logic                eng_start,
  input  logic                eng_done,
  input  logic [W-1:0]        eng_result,
  output logic                busy,
  output logic                timeout_err,
  output logic [7:0]          jobs_done
);

  localparam int unsigned LW = $clog2(TIMEOUT);
  localparam int unsigned AW = $clog2(DEPTH);

  disp_state_t   state_q;
  logic [LW-1:0] lat_q, lat_d;
  logic [W-1:0]  eng_x_q;
  logic          eng_start_q;
  logic          timeout_err_q;
  logic [7:0]    jobs_q;
  logic          run_q;

  logic          accept;
  logic          fifo_wr;
  logic          fifo_full;
  logic          fifo_empty;
  logic [AW:0]   fifo_free;

  // Only one job is ever in flight and it is accepted only with a free slot,
  // so the capture write always finds room; the full gate is belt-and-braces.
  always_comb begin
    lat_d   = lat_q + LW'(1);
    accept  = in_s.valid && in_s.ready;
    fifo_wr = (state_q == S_CAPTURE) && !fifo_full;
  end

  // run_q keeps in_ready low while reset is asserted.
  assign in_s.ready  = run_q && (state_q == S_IDLE) && (fifo_free != '0);
  assign eng_x       = eng_x_q;
  assign eng_start   = eng_start_q;
  assign busy        = (state_q != S_IDLE);
  assign timeout_err = timeout_err_q;
  assign jobs_done   = jobs_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      lat_q         <= '0;
      eng_x_q       <= '0;
      eng_start_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      jobs_q        <= '0;
      run_q         <= 1'b0;
    end else begin
      run_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            eng_x_q     <= in_s.data;
            lat_q       <= '0;
            eng_start_q <= 1'b1;
            state_q     <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          eng_start_q <= 1'b0;
          state_q     <= S_GUARD;
        end
        // Comparisons use the incremented count so done is trusted from
        // MIN_LAT cycles after the start pulse.
        S_GUARD: begin
          lat_q <= lat_d;
          if (lat_d == LW'(MIN_LAT - 1)) state_q <= S_WAIT;
        end
        S_WAIT: begin
          lat_q <= lat_d;
          if (eng_done) begin
            state_q <= S_CAPTURE;
          end else if (lat_d == LW'(TIMEOUT - 1)) begin
            timeout_err_q <= 1'b1;
            state_q       <= S_IDLE;
          end
        end
        S_CAPTURE: begin
          jobs_q  <= jobs_q + 8'd1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  result_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (fifo_wr),
    .wr_data  (eng_result),
    .full     (fifo_full),
    .free_cnt (fifo_free),
    .rd_en    (out_m.ready),
    .rd_data  (out_m.data),
    .empty    (fifo_empty)
  );

  assign out_m.valid = !fifo_empty;

endmodule

// File: tb/tb_series_dispatcher.sv
// Scoreboard bench for series_dispatcher: a behavioural engine model answers
// each start with result = x + 16'h1134 after a chosen delay; expected results
// are queued at start and compared in order as the DUT emits them.
module tb_series_dispatcher;

  localparam int MIN_LAT = 4;
  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] eng_x;
  logic        eng_start;
  logic        eng_done;
  logic [15:0] eng_result;
  logic        busy;
  logic        timeout_err;
  logic [7:0]  jobs_done;

  series_stream_if #(.W(16)) in_if ();
  series_stream_if #(.W(16)) out_if ();

  series_dispatcher #(
    .W(16), .DEPTH(4), .MIN_LAT(MIN_LAT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_s        (in_if.slave),
    .out_m       (out_if.master),
    .eng_x       (eng_x),
    .eng_start   (eng_start),
    .eng_done    (eng_done),
    .eng_result  (eng_result),
    .busy        (busy),
    .timeout_err (timeout_err),
    .jobs_done   (jobs_done)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_err    = 0;
  int          cyc      = 0;
  int          n_acc    = 0;
  int          n_starts = 0;
  int          n_writes = 0;
  int          last_start = 0;
  int          eng_mode = 0;   // 0 normal, 1 done stuck high, 2 never done
  int          fixed_d  = 0;   // >0 forces the done delay
  int          rdy_mode = 0;   // 0 low, 1 high, 2 random, 3 high only at pulse_cyc
  int          pulse_cyc = -1;
  logic [15:0] sent_q[$];
  logic [15:0] exp_q[$];

  function automatic logic [15:0] ref_result(input logic [15:0] x);
    return x + 16'h1134;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Downstream ready driver
  initial begin
    out_if.ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       out_if.ready = 1'b0;
        1:       out_if.ready = 1'b1;
        2:       out_if.ready = 1'($urandom_range(1, 0));
        default: out_if.ready = (cyc == pulse_cyc);
      endcase
    end
  end

  // Monitor: every downstream handshake pops one expected result
  initial forever begin
    @(negedge clk);
    if (rst_n && out_if.valid && out_if.ready) begin
      if (exp_q.size() == 0) check("unexpected_output", 32'(out_if.data), 32'hffffffff);
      else check("out_data", 32'(out_if.data), 32'(exp_q.pop_front()));
    end
  end

  // Engine model
  initial begin : engine
    int          cnt;
    int          d;
    logic [15:0] x;
    logic        active;
    logic        glitch;
    logic        prev_start;
    cnt = 0; d = 0; x = '0; active = 0; glitch = 0; prev_start = 0;
    eng_done = 1'b0; eng_result = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        active = 0; prev_start = 0;
      end else if (eng_start) begin
        check("start_single_cycle", 32'(prev_start), 32'd0);
        prev_start = 1; n_starts++; last_start = cyc;
        if (sent_q.size() == 0) begin
          check("start_without_accept", 32'd1, 32'd0);
          x = eng_x;
        end else begin
          x = sent_q.pop_front();
          check("eng_x", 32'(eng_x), 32'(x));
        end
        cnt    = 0;
        active = (eng_mode == 0);
        d      = (fixed_d > 0) ? fixed_d : int'($urandom_range(14, MIN_LAT));
        glitch = (eng_mode == 0) && (fixed_d == 0) && ($urandom_range(3, 0) == 0);
        eng_done = (eng_mode == 1);
        if (eng_mode == 1) eng_result = ref_result(x);
        if (eng_mode != 2) begin
          exp_q.push_back(ref_result(x));
          n_writes++;
        end
      end else begin
        prev_start = 0;
        if (eng_mode == 1) eng_done = 1'b1;
        if (active) begin
          cnt++;
          if (glitch && cnt == 1) begin eng_done = 1'b1; eng_result = 16'hdead; end
          if (glitch && cnt == 2) eng_done = 1'b0;
          if (cnt == d) begin
            eng_done = 1'b1; eng_result = ref_result(x); active = 0;
          end
        end
      end
    end
  end

  task automatic send(input logic [15:0] x);
    int t;
    t = 0;
    @(posedge clk); #1;
    in_if.valid = 1'b1; in_if.data = x;
    @(negedge clk);
    while (in_if.ready !== 1'b1 && t < 400) begin t++; @(negedge clk); end
    if (in_if.ready !== 1'b1) check("accept_timeout", 32'd0, 32'd1);
    else begin sent_q.push_back(x); n_acc++; end
    @(posedge clk); #1;
    in_if.valid = 1'b0;
  endtask

  task automatic wait_start(input int prev);
    int t;
    t = 0;
    @(negedge clk);
    while (n_starts == prev && t < 50) begin t++; @(negedge clk); end
    if (n_starts == prev) check("start_timeout", 32'd0, 32'd1);
  endtask

  task automatic at_cycle(input int c);
    @(negedge clk);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while (busy && t < 200) begin t++; @(negedge clk); end
    if (busy) check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic drain();
    int t;
    t = 0;
    rdy_mode = 1;
    @(negedge clk);
    while ((exp_q.size() != 0 || busy || out_if.valid) && t < 500) begin t++; @(negedge clk); end
    check("drain_exp_empty", 32'(exp_q.size()), 32'd0);
    rdy_mode = 0;
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int s;
    int prev;
    int acc0;
    rst_n = 1'b0; in_if.valid = 1'b0; in_if.data = '0;

    // Reset state
    #12;
    check("rst_in_ready", 32'(in_if.ready), 0);
    check("rst_out_valid", 32'(out_if.valid), 0);
    check("rst_out_data", 32'(out_if.data), 0);
    check("rst_eng_start", 32'(eng_start), 0);
    check("rst_eng_x", 32'(eng_x), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_timeout_err", 32'(timeout_err), 0);
    check("rst_jobs_done", 32'(jobs_done), 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single job, done at start+6
    fixed_d = 6; eng_mode = 0; rdy_mode = 0;
    prev = n_starts;
    send(16'h0100);
    wait_start(prev); s = last_start;
    at_cycle(s + 7); check("t1_out_valid_early", 32'(out_if.valid), 0);
    at_cycle(s + 8); check("t1_out_valid", 32'(out_if.valid), 1);
    check("t1_out_head", 32'(out_if.data), 32'h1234);
    check("t1_one_start", 32'(n_starts), 1);
    drain();
    check("t1_jobs_done", 32'(jobs_done), 1);

    // Done stuck high: ignored while idle and during the guard window
    eng_mode = 1; fixed_d = 0;
    repeat (5) @(negedge clk);
    check("t2_idle_ignores_done", 32'(busy), 0);
    prev = n_starts;
    send(16'h4321);
    wait_start(prev); s = last_start;
    at_cycle(s + MIN_LAT + 1); check("t2_not_early", 32'(out_if.valid), 0);
    at_cycle(s + MIN_LAT + 2); check("t2_captured", 32'(out_if.valid), 1);
    drain();

    // Backpressure: four results fill the FIFO, fifth waits for a pop
    eng_mode = 0; rdy_mode = 0;
    acc0 = n_acc;
    for (int i = 0; i < 4; i++) send(16'($urandom));
    wait_idle();
    check("t3_full_in_ready", 32'(in_if.ready), 0);
    check("t3_full_out_valid", 32'(out_if.valid), 1);
    fork
      send(16'h5555);
      begin
        repeat (8) @(negedge clk);
        check("t3_no_accept_full", 32'(n_acc), 32'(acc0 + 4));
        pulse_cyc = cyc + 1; rdy_mode = 3;
      end
    join
    check("t3_fifth_accepted", 32'(n_acc), 32'(acc0 + 5));
    rdy_mode = 0;
    drain();

    // Simultaneous write and pop at 3 entries keeps occupancy at 3
    for (int i = 0; i < 3; i++) send(16'($urandom));
    wait_idle();
    check("t5_three_in_ready", 32'(in_if.ready), 1);
    fixed_d = 5;
    prev = n_starts;
    send(16'h0a0a);
    wait_start(prev);
    pulse_cyc = last_start + 5 + 1; rdy_mode = 3;
    wait_idle();
    @(negedge clk);
    check("t5_pushpop_in_ready", 32'(in_if.ready), 1);
    rdy_mode = 0; fixed_d = 0;
    send(16'h0b0b);
    wait_idle();
    check("t5_now_full", 32'(in_if.ready), 0);
    drain();

    // Latest trusted done is still captured
    fixed_d = TIMEOUT - 1;
    send(16'h7777);
    wait_idle();
    check("bnd_no_timeout", 32'(timeout_err), 0);
    check("bnd_captured", 32'(out_if.valid), 1);
    fixed_d = 0;
    drain();

    // Random traffic through many pointer wraps and a jobs_done wrap
    rdy_mode = 2;
    for (int i = 0; i < 270; i++) send(16'($urandom));
    drain();
    check("rnd_jobs_done", 32'(jobs_done), 32'(8'(n_writes)));

    // Timeout
    eng_mode = 2;
    prev = n_starts;
    send(16'hbeef);
    wait_start(prev); s = last_start;
    at_cycle(s + TIMEOUT - 1);
    check("t4_err_before", 32'(timeout_err), 0);
    check("t4_busy_before", 32'(busy), 1);
    at_cycle(s + TIMEOUT);
    check("t4_err", 32'(timeout_err), 1);
    check("t4_idle", 32'(busy), 0);
    check("t4_no_write", 32'(out_if.valid), 0);
    check("t4_jobs_unchanged", 32'(jobs_done), 32'(8'(n_writes)));
    check("t4_in_ready", 32'(in_if.ready), 1);

    // Async reset during the wait phase
    prev = n_starts;
    send(16'hcafe);
    wait_start(prev); s = last_start;
    at_cycle(s + 10);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("t6_busy", 32'(busy), 0);
    check("t6_eng_start", 32'(eng_start), 0);
    check("t6_eng_x", 32'(eng_x), 0);
    check("t6_in_ready", 32'(in_if.ready), 0);
    check("t6_out_valid", 32'(out_if.valid), 0);
    check("t6_out_data", 32'(out_if.data), 0);
    check("t6_timeout_err", 32'(timeout_err), 0);
    check("t6_jobs_done", 32'(jobs_done), 0);
    sent_q.delete(); exp_q.delete(); n_writes = 0;
    eng_mode = 1;
    @(negedge clk); rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("t6_late_done_out_valid", 32'(out_if.valid), 0);
    check("t6_late_done_jobs", 32'(jobs_done), 0);
    check("t6_late_done_busy", 32'(busy), 0);
    check("starts_match_accepts", 32'(n_starts), 32'(n_acc));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
